// File: rtl/mpu_gyro_assembler.sv
// Turns completed I2C gyro burst reads into signed X/Y/Z samples with a 1-cycle valid strobe.
// Optional start-up bias removal is built when the CALIB_EN macro is defined.
module mpu_gyro_assembler #(
  parameter int SKIP_EVENTS = 2,
  parameter int CAL_LOG2    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               end_flag,
  input  logic [7:0]         received_data [8],
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic               sample_valid,
  output logic               calib_done
);

  localparam int SKIP_W = (SKIP_EVENTS > 0) ? $clog2(SKIP_EVENTS + 1) : 1;

  typedef enum logic [1:0] {S_WAIT, S_PROC, S_CAL} state_t;
  state_t state_q, state_d;

  logic              sync_ff1, sync_q, sync_q_d;
  logic              edge_evt, skip_done, take_evt;
  logic [SKIP_W-1:0] skip_cnt;
  logic signed [15:0] raw_x, raw_y, raw_z;
  logic              calibrating;
  logic              latch_raw, do_out;
`ifdef CALIB_EN
  logic              do_cal;
`endif

  assign edge_evt  = sync_q & ~sync_q_d;
  assign skip_done = (skip_cnt == SKIP_W'(SKIP_EVENTS));
  assign take_evt  = edge_evt & skip_done & (state_q == S_WAIT);

  // end_flag comes from a slower derived clock, so it is double-flopped before edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b0;
      sync_q   <= 1'b0;
      sync_q_d <= 1'b0;
      skip_cnt <= '0;
    end else begin
      sync_ff1 <= end_flag;
      sync_q   <= sync_ff1;
      sync_q_d <= sync_q;
      if (edge_evt && !skip_done) skip_cnt <= skip_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_raw = 1'b0;
    do_out    = 1'b0;
`ifdef CALIB_EN
    do_cal    = 1'b0;
`endif
    case (state_q)
      S_WAIT: if (take_evt) begin
        latch_raw = 1'b1;
        state_d   = S_PROC;
      end
      S_PROC: begin
        if (calibrating) state_d = S_CAL;
        else begin
          do_out  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_CAL: begin
`ifdef CALIB_EN
        do_cal  = 1'b1;
`endif
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Each word is big-endian in the burst: high byte at the lower index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_x <= '0;
      raw_y <= '0;
      raw_z <= '0;
    end else if (latch_raw) begin
      raw_x <= {received_data[0], received_data[1]};
      raw_y <= {received_data[2], received_data[3]};
      raw_z <= {received_data[4], received_data[5]};
    end
  end

`ifdef CALIB_EN
  localparam int ACC_W = 16 + CAL_LOG2;

  logic                      calib_q;
  logic [CAL_LOG2-1:0]       cal_cnt;
  logic signed [ACC_W-1:0]   acc_x, acc_y, acc_z;
  logic signed [ACC_W-1:0]   sum_x, sum_y, sum_z;
  logic signed [15:0]        bias_x, bias_y, bias_z;

  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {a[15], a} - {b[15], b};
    // Overflow iff the 17-bit sign disagrees with bit 15.
    if (d[16] != d[15]) sat_sub = d[16] ? 16'h8000 : 16'h7FFF;
    else                sat_sub = d[15:0];
  endfunction

  assign calibrating = ~calib_q;
  assign calib_done  = calib_q;
  assign sum_x = acc_x + {{CAL_LOG2{raw_x[15]}}, raw_x};
  assign sum_y = acc_y + {{CAL_LOG2{raw_y[15]}}, raw_y};
  assign sum_z = acc_z + {{CAL_LOG2{raw_z[15]}}, raw_z};

  // Bias is the arithmetic mean of the window, including the sample that completes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_q <= 1'b0;
      cal_cnt <= '0;
      acc_x   <= '0;
      acc_y   <= '0;
      acc_z   <= '0;
      bias_x  <= '0;
      bias_y  <= '0;
      bias_z  <= '0;
    end else if (do_cal) begin
      acc_x   <= sum_x;
      acc_y   <= sum_y;
      acc_z   <= sum_z;
      cal_cnt <= cal_cnt + 1'b1;
      if (&cal_cnt) begin
        bias_x  <= sum_x[CAL_LOG2 +: 16];
        bias_y  <= sum_y[CAL_LOG2 +: 16];
        bias_z  <= sum_z[CAL_LOG2 +: 16];
        calib_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= do_out;
      if (do_out) begin
        gyro_x <= sat_sub(raw_x, bias_x);
        gyro_y <= sat_sub(raw_y, bias_y);
        gyro_z <= sat_sub(raw_z, bias_z);
      end
    end
  end
`else
  logic unused_ok;

  assign calibrating = 1'b0;
  assign calib_done  = 1'b1;
  assign unused_ok   = &{1'b0, received_data[6], received_data[7], CAL_LOG2[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= do_out;
      if (do_out) begin
        gyro_x <= raw_x;
        gyro_y <= raw_y;
        gyro_z <= raw_z;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mpu_gyro_assembler.sv
// Directed bench for mpu_gyro_assembler: skip window, latency, byte mapping, held flag, reset;
// calibration and saturation sequences when CALIB_EN is defined (CAL_LOG2 = 2).
module tb_mpu_gyro_assembler;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               end_flag = 1'b0;
  logic [7:0]         rx_data [8];
  logic signed [15:0] gyro_x, gyro_y, gyro_z;
  logic               sample_valid, calib_done;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int v0;

  typedef struct {
    logic [47:0] bytes;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
    logic [15:0] exp_z;
  } vec_t;

  vec_t vecs [4];

  mpu_gyro_assembler #(.SKIP_EVENTS(2), .CAL_LOG2(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .end_flag      (end_flag),
    .received_data (rx_data),
    .gyro_x        (gyro_x),
    .gyro_y        (gyro_y),
    .gyro_z        (gyro_z),
    .sample_valid  (sample_valid),
    .calib_done    (calib_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (sample_valid === 1'b1) valid_cnt++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_bytes(input logic [47:0] b);
    for (int i = 0; i < 6; i++) rx_data[i] = b[47 - 8*i -: 8];
    rx_data[6] = 8'($urandom_range(0, 255));
    rx_data[7] = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse(input logic [47:0] b, input int hi);
    @(negedge clk);
    set_bytes(b);
    end_flag = 1'b1;
    repeat (hi) @(negedge clk);
    end_flag = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rx_data[i] = 8'h00;
    vecs[0] = '{48'h0123_FFFE_8000, 16'h0123, 16'hFFFE, 16'h8000};
    vecs[1] = '{48'h7FFF_0001_0000, 16'h7FFF, 16'h0001, 16'h0000};
    vecs[2] = '{48'hDEAD_BEEF_1234, 16'hDEAD, 16'hBEEF, 16'h1234};
    vecs[3] = '{48'h0000_8001_FFFF, 16'h0000, 16'h8001, 16'hFFFF};

    repeat (3) @(negedge clk);
    chk("rst_gyro_x", gyro_x, 16'h0000);
    chk("rst_gyro_y", gyro_y, 16'h0000);
    chk("rst_gyro_z", gyro_z, 16'h0000);
    chk("rst_valid", {15'd0, sample_valid}, 16'h0000);
`ifdef CALIB_EN
    chk("rst_calib_done", {15'd0, calib_done}, 16'h0000);
`else
    chk("rst_calib_done", {15'd0, calib_done}, 16'h0001);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // The first two transactions are configuration writes and must be swallowed.
    v0 = valid_cnt;
    pulse(48'h1111_2222_3333, 4);
    pulse(48'h4444_5555_6666, 4);
    chk("skip_no_valid", 16'(valid_cnt - v0), 16'd0);
    chk("skip_gyro_x", gyro_x, 16'h0000);

`ifndef CALIB_EN
    // Exact latency: strobe lands on the 4th clock after end_flag rises.
    @(negedge clk);
    set_bytes(48'h0123_FFFE_8000);
    end_flag = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_early", {15'd0, sample_valid}, 16'h0000);
    @(negedge clk);
    chk("lat_strobe", {15'd0, sample_valid}, 16'h0001);
    chk("lat_x", gyro_x, 16'h0123);
    chk("lat_y", gyro_y, 16'hFFFE);
    chk("lat_z", gyro_z, 16'h8000);
    @(negedge clk);
    chk("lat_one_cycle", {15'd0, sample_valid}, 16'h0000);
    end_flag = 1'b0;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      pulse(vecs[i].bytes, 4);
      chk($sformatf("vec%0d_valid", i), 16'(valid_cnt - v0), 16'd1);
      chk($sformatf("vec%0d_x", i), gyro_x, vecs[i].exp_x);
      chk($sformatf("vec%0d_y", i), gyro_y, vecs[i].exp_y);
      chk($sformatf("vec%0d_z", i), gyro_z, vecs[i].exp_z);
    end

    v0 = valid_cnt;
    pulse(48'h0F0F_1234_ABCD, 40);
    chk("held_one_valid", 16'(valid_cnt - v0), 16'd1);
    chk("held_x", gyro_x, 16'h0F0F);
    chk("held_gyro_hold", gyro_z, 16'hABCD);

    // Reset while a sample is in flight, then the skip window must restart.
    @(negedge clk);
    set_bytes(48'h5555_6666_7777);
    end_flag = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_x", gyro_x, 16'h0000);
    chk("midrst_z", gyro_z, 16'h0000);
    chk("midrst_valid", {15'd0, sample_valid}, 16'h0000);
    @(negedge clk);
    end_flag = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    pulse(48'h1111_1111_1111, 4);
    pulse(48'h2222_2222_2222, 4);
    chk("midrst_skip", 16'(valid_cnt - v0), 16'd0);
    pulse(vecs[2].bytes, 4);
    chk("midrst_resume", 16'(valid_cnt - v0), 16'd1);
    chk("midrst_resume_x", gyro_x, 16'hDEAD);
`else
    // Window of 4: X mean 13, Y and Z mean 0.
    v0 = valid_cnt;
    pulse(48'h000A_0000_0000, 4);
    pulse(48'h000C_0000_0000, 4);
    pulse(48'h000E_0000_0000, 4);
    chk("cal_not_done_yet", {15'd0, calib_done}, 16'h0000);
    pulse(48'h0010_0000_0000, 4);
    chk("cal_no_valid", 16'(valid_cnt - v0), 16'd0);
    chk("cal_done", {15'd0, calib_done}, 16'h0001);
    chk("cal_gyro_x_idle", gyro_x, 16'h0000);

    v0 = valid_cnt;
    pulse(48'h0014_0005_FFFD, 4);
    chk("corr_valid", 16'(valid_cnt - v0), 16'd1);
    chk("corr_x", gyro_x, 16'h0007);
    chk("corr_y", gyro_y, 16'h0005);
    chk("corr_z", gyro_z, 16'hFFFD);

    pulse(48'h8000_7FFF_0000, 4);
    chk("sat_neg_x", gyro_x, 16'h8000);
    chk("sat_pos_y", gyro_y, 16'h7FFF);

    do_reset();
    chk("rst2_x", gyro_x, 16'h0000);
    chk("rst2_calib_done", {15'd0, calib_done}, 16'h0000);

    // Abort a calibration halfway; skip and sample count must both restart.
    pulse(48'h1111_1111_1111, 4);
    pulse(48'h2222_2222_2222, 4);
    pulse(48'hFF9C_0000_0000, 4);
    pulse(48'hFF9C_0000_0000, 4);
    do_reset();
    chk("rst3_calib_done", {15'd0, calib_done}, 16'h0000);
    v0 = valid_cnt;
    pulse(48'h1111_1111_1111, 4);
    pulse(48'h2222_2222_2222, 4);
    pulse(48'hFF9C_0000_0000, 4);
    pulse(48'hFF9C_0000_0000, 4);
    pulse(48'hFF9C_0000_0000, 4);
    chk("recal_partial", {15'd0, calib_done}, 16'h0000);
    pulse(48'hFF9C_0000_0000, 4);
    chk("recal_done", {15'd0, calib_done}, 16'h0001);
    chk("recal_no_valid", 16'(valid_cnt - v0), 16'd0);
    pulse(48'h7FF0_0001_0000, 4);
    chk("sat_pos_x", gyro_x, 16'h7FFF);
    chk("sat_y", gyro_y, 16'h0001);
    chk("sat_valid", 16'(valid_cnt - v0), 16'd1);
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
